// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined RV32M/RV64M multiplier.
// The stage payload is sized for the widest legal configuration so one struct serves every build.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mult_op_e;

    localparam int XLEN_MAX = 64;
    // Tags wider than this are truncated; 16 bits covers any register index plus spare ids.
    localparam int TAG_MAX  = 16;

    typedef struct packed {
        logic [2*XLEN_MAX-1:0] acc;
        logic [XLEN_MAX-1:0]   a_mag;
        logic [XLEN_MAX-1:0]   b_mag;
        logic                  neg;
        logic                  upper;
        logic [TAG_MAX-1:0]    tag;
    } stage_payload_t;

    function automatic int chunk_width(input int xlen, input int stages);
        return (xlen + stages - 1) / stages;
    endfunction

    // Returns {signed_A, signed_B, upper}; the low half of MUL does not depend on signedness.
    function automatic logic [2:0] op_controls(input mult_op_e op);
        logic [2:0] ctl;
        ctl = 3'b110;
        case (op)
            MUL:     ctl = 3'b110;
            MULH:    ctl = 3'b111;
            MULHSU:  ctl = 3'b101;
            MULHU:   ctl = 3'b001;
            default: ctl = 3'b110;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiply-accumulate step: adds |A| times chunk K of |B| into the running product.
// Holds when the pipe stalls; flush clears only the valid bit.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int CW = 8,
    parameter int K  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           flush,
    input  logic           prev_valid,
    input  stage_payload_t prev_data,
    output logic           valid,
    output stage_payload_t data
);

    localparam int ACC_W = 2 * XLEN_MAX;
    localparam int SHIFT = K * CW;
    localparam logic [ACC_W-1:0] CHUNK_MASK = (ACC_W'(1) << CW) - ACC_W'(1);

    logic [ACC_W-1:0] chunk;
    logic [ACC_W-1:0] partial;
    stage_payload_t   next_data;

    // Bits of |B| beyond XLEN are zero, so the last chunk is naturally zero-padded.
    always_comb begin
        chunk         = ({{XLEN_MAX{1'b0}}, prev_data.b_mag} >> SHIFT) & CHUNK_MASK;
        partial       = ({{XLEN_MAX{1'b0}}, prev_data.a_mag} * chunk) << SHIFT;
        next_data     = prev_data;
        next_data.acc = prev_data.acc + partial;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (enable) begin
            valid <= prev_valid;
            data  <= next_data;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined MUL/MULH/MULHSU/MULHU unit: one op per cycle, result STAGES cycles after accept.
// The whole pipe advances in lockstep and stalls only when the output is held by the consumer.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  op_A_i,
    input  logic [XLEN-1:0]  op_B_i,
    input  logic             signed_A_i,
    input  logic             signed_B_i,
    input  logic             upper_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CW = chunk_width(XLEN, STAGES);

    logic                  advance;
    logic                  accept;
    logic                  a_neg;
    logic                  b_neg;
    logic [XLEN-1:0]       a_mag;
    logic [XLEN-1:0]       b_mag;
    stage_payload_t        entry;
    stage_payload_t        stage_data  [STAGES+1];
    logic                  stage_valid [STAGES+1];
    logic [2*XLEN_MAX-1:0] signed_product;
    logic [XLEN-1:0]       selected;

    assign in_ready_o = flush_i || !(out_valid_o && !out_ready_i);
    assign advance    = in_ready_o;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    // Negating the most negative value yields the same bit pattern, which is its exact magnitude.
    always_comb begin
        a_neg       = signed_A_i && op_A_i[XLEN-1];
        b_neg       = signed_B_i && op_B_i[XLEN-1];
        a_mag       = a_neg ? -op_A_i : op_A_i;
        b_mag       = b_neg ? -op_B_i : op_B_i;
        entry       = '0;
        entry.a_mag = XLEN_MAX'(a_mag);
        entry.b_mag = XLEN_MAX'(b_mag);
        entry.neg   = a_neg ^ b_neg;
        entry.upper = upper_i;
        entry.tag   = TAG_MAX'(tag_i);
    end

    assign stage_valid[0] = accept;
    assign stage_data[0]  = entry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mult_pipe_stage #(
            .CW (CW),
            .K  (k)
        ) u_stage (
            .clk        (clk_i),
            .rst_n      (rst_i),
            .enable     (advance),
            .flush      (flush_i),
            .prev_valid (stage_valid[k]),
            .prev_data  (stage_data[k]),
            .valid      (stage_valid[k+1]),
            .data       (stage_data[k+1])
        );
    end

    always_comb begin
        signed_product = stage_data[STAGES].neg ? -stage_data[STAGES].acc : stage_data[STAGES].acc;
        selected       = stage_data[STAGES].upper ? XLEN'(signed_product >> XLEN)
                                                  : XLEN'(signed_product);
    end

    // Payload only reloads on a real result so it stays put across idle cycles as well as stalls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            tag_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (advance) begin
            out_valid_o <= stage_valid[STAGES];
            if (stage_valid[STAGES]) begin
                result_o <= selected;
                tag_o    <= TAG_W'(stage_data[STAGES].tag);
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: directed vectors, stalls, flush, mid-stream reset and random ops
// checked against a plain-arithmetic product model.
module tb_mult_pipe;
    import mult_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 5;

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b0;
    logic             flush_i     = 1'b0;
    logic             in_valid_i  = 1'b0;
    logic             in_ready_o;
    logic [XLEN-1:0]  op_A_i      = '0;
    logic [XLEN-1:0]  op_B_i      = '0;
    logic             signed_A_i  = 1'b0;
    logic             signed_B_i  = 1'b0;
    logic             upper_i     = 1'b0;
    logic [TAG_W-1:0] tag_i       = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    typedef struct {
        logic [XLEN-1:0]  result;
        logic [TAG_W-1:0] tag;
        int               edge_n;
        bit               chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   tests       = 0;
    int   fails       = 0;
    int   cycle       = 0;
    int   ready_mode  = 0;
    int   stall_from  = 0;
    int   stall_until = 0;

    mult_pipe #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_A_i      (op_A_i),
        .op_B_i      (op_B_i),
        .signed_A_i  (signed_A_i),
        .signed_B_i  (signed_B_i),
        .upper_i     (upper_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] ctl);
        logic [2*XLEN-1:0] ae;
        logic [2*XLEN-1:0] be;
        logic [2*XLEN-1:0] p;
        ae = ctl[2] ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        be = ctl[1] ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ae * be;
        return ctl[0] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [2:0] ctl, input logic [TAG_W-1:0] tag, input logic flush,
                                 input logic [XLEN-1:0] exp_result, input bit chk_lat, output bit accepted);
        @(negedge clk_i);
        in_valid_i = valid;
        op_A_i     = a;
        op_B_i     = b;
        {signed_A_i, signed_B_i, upper_i} = ctl;
        tag_i      = tag;
        flush_i    = flush;
        case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = !(cycle >= stall_from && cycle < stall_until);
            default: out_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        accepted = valid && in_ready_o && !flush;
        if (accepted) exp_q.push_back('{exp_result, tag, cycle + 1, chk_lat});
        if (flush) begin
            @(posedge clk_i);
            #1;
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) applyStimulus(1'b0, '0, '0, 3'b000, '0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic issueOp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [2:0] ctl,
                           input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_result, input bit chk_lat);
        bit acc;
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, a, b, ctl, tag, 1'b0, exp_result, chk_lat, acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: request not accepted in %0d cycles, required acceptance", tries);
        end
    endtask

    function automatic logic [XLEN-1:0] pickOperand();
        logic [XLEN-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = {1'b1, {(XLEN-1){1'b0}}};
            1:       v = '1;
            2:       v = '0;
            default: v = XLEN'($urandom);
        endcase
        return v;
    endfunction

    task automatic randomOp(input bit chk_lat);
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [2:0]       ctl;
        logic [TAG_W-1:0] tag;
        a   = pickOperand();
        b   = pickOperand();
        ctl = op_controls(mult_op_e'($urandom_range(0, 3)));
        tag = TAG_W'($urandom);
        issueOp(a, b, ctl, tag, model(a, b, ctl), chk_lat);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        idle(2);
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor samples mid-low-phase, after the driver has settled this cycle's inputs.
    bit               head_new = 1'b1;
    logic [XLEN-1:0]  held_result;
    logic [TAG_W-1:0] held_tag;

    always @(negedge clk_i) begin
        #2;
        if (!rst_i) begin
            head_new = 1'b1;
        end else begin
            checkOutput("in_ready", 64'(in_ready_o), 64'(flush_i || !(out_valid_o && !out_ready_i)));
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_result: got result 0x%0h tag %0d, required no output",
                             result_o, tag_o);
                    head_new = out_ready_i;
                end else begin
                    if (head_new) begin
                        if (exp_q[0].chk_lat)
                            checkOutput("latency", 64'(cycle), 64'(exp_q[0].edge_n + STAGES));
                    end else begin
                        checkOutput("stall_result_stable", 64'(result_o), 64'(held_result));
                        checkOutput("stall_tag_stable", 64'(tag_o), 64'(held_tag));
                    end
                    checkOutput("result", 64'(result_o), 64'(exp_q[0].result));
                    checkOutput("tag", 64'(tag_o), 64'(exp_q[0].tag));
                    held_result = result_o;
                    held_tag    = tag_o;
                    head_new    = 1'b0;
                    if (out_ready_i) begin
                        void'(exp_q.pop_front());
                        head_new = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [XLEN-1:0] dir_a;
    logic [XLEN-1:0] dir_b;
    mult_op_e        dir_ops [4];
    logic [XLEN-1:0] dir_exp [4];

    initial begin
        bit acc;
        dir_a      = 32'h8000_0001;
        dir_b      = 32'h8001_0002;
        dir_ops    = '{MUL, MULH, MULHSU, MULHU};
        dir_exp    = '{32'h8001_0002, 32'h3FFF_7FFE, 32'hBFFF_7FFF, 32'h4000_8001};

        #12;
        checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset_result", 64'(result_o), 64'd0);
        checkOutput("reset_tag", 64'(tag_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready_o), 64'd1);

        for (int i = 0; i < 4; i++) begin
            issueOp(dir_a, dir_b, op_controls(dir_ops[i]), TAG_W'(i + 1), dir_exp[i], 1'b1);
            idle(STAGES + 2);
        end

        for (int i = 0; i < 4; i++)
            issueOp(dir_a, dir_b, op_controls(dir_ops[i]), TAG_W'(i + 1), dir_exp[i], 1'b1);
        drain();

        issueOp(32'h8000_0000, 32'h8000_0000, op_controls(MULH), 5'd10, 32'h4000_0000, 1'b1);
        issueOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, op_controls(MULH), 5'd11, 32'h0000_0000, 1'b1);
        issueOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, op_controls(MULHU), 5'd12, 32'hFFFF_FFFE, 1'b1);
        drain();

        ready_mode  = 1;
        stall_from  = cycle + 6;
        stall_until = stall_from + 3;
        for (int i = 0; i < 10; i++) randomOp(1'b0);
        drain();
        ready_mode = 0;

        for (int i = 0; i < 3; i++) randomOp(1'b0);
        applyStimulus(1'b1, 32'd5, 32'd5, op_controls(MUL), 5'd30, 1'b1, 32'd25, 1'b0, acc);
        issueOp(32'd7, 32'd9, op_controls(MUL), 5'd21, 32'h0000_003F, 1'b1);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 40; i++) randomOp(1'b0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #3;
        rst_i = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("midreset_result", 64'(result_o), 64'd0);
        checkOutput("midreset_tag", 64'(tag_o), 64'd0);
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(STAGES + 3);
        for (int i = 0; i < 30; i++) randomOp(1'b0);
        drain();

        ready_mode = 0;
        for (int i = 0; i < 20; i++) randomOp(1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
